// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Iterative RV32M multiply/divide unit that sits beside the single-cycle ALU in
// EX. It takes one operation per valid/ready handshake and retires one bit per
// clock: shift-add for the multiplies and restoring division for the divides.
// The result is held until the consumer takes it. flush aborts any in-flight or
// held operation.
//
// Optional build macro:
//   MULDIV_EARLY_OUT_EN - divide-by-zero, signed overflow and multiplies with a
//                         zero operand skip CALC. They go straight from the
//                         accepting edge to FIX. The result values are the same
//                         as on the normal path.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   flush      in   synchronous abort (highest priority after rst)
//   in_valid   in   request valid
//   in_ready   out  unit can accept (high only in IDLE)
//   func       in   0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   op1        in   rs1 value (sampled only at acceptance)
//   op2        in   rs2 value (sampled only at acceptance)
//   out_valid  out  result valid
//   out_ready  in   consumer takes result
//   result     out  registered result
// -----------------------------------------------------------------------------
module muldiv_unit #(
    parameter int DataWidth = 32,
    parameter int CntWidth  = $clog2(DataWidth) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           func,
    input  logic [DataWidth-1:0] op1,
    input  logic [DataWidth-1:0] op2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DataWidth-1:0] result
);

    localparam int W = DataWidth;

    localparam logic [2:0] F_MUL    = 3'd0;
    localparam logic [2:0] F_MULH   = 3'd1;
    localparam logic [2:0] F_MULHSU = 3'd2;
    localparam logic [2:0] F_MULHU  = 3'd3;
    localparam logic [2:0] F_DIV    = 3'd4;
    localparam logic [2:0] F_DIVU   = 3'd5;
    localparam logic [2:0] F_REM    = 3'd6;

    localparam logic [CntWidth-1:0] LastCnt = CntWidth'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    // Architectural state
    state_t              state_q;
    logic [2:0]          func_q;
    logic                sign1_q;     // effective sign of op1 (0 for unsigned uses)
    logic                sign2_q;     // effective sign of op2 (0 for unsigned uses)
    logic                div0_q;      // divide with op2 == 0
    logic [W-1:0]        hi_q;        // product high half / partial remainder
    logic [W-1:0]        lo_q;        // multiplier -> product low / dividend -> quotient
    logic [W-1:0]        mcand_q;     // multiplicand or divisor magnitude
    logic [CntWidth-1:0] cnt_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic [W-1:0]        result_q;

    // -------------------------------------------------------------------------
    // Request decode (used only at the accepting edge)
    // -------------------------------------------------------------------------
    logic         signed1_in;
    logic         signed2_in;
    logic         neg1_in;
    logic         neg2_in;
    logic [W-1:0] mag1_in;
    logic [W-1:0] mag2_in;
    logic         div0_in;

    always_comb begin
        signed1_in = (func == F_MULH) || (func == F_MULHSU) ||
                     (func == F_DIV)  || (func == F_REM);
        signed2_in = (func == F_MULH) || (func == F_DIV) || (func == F_REM);
        neg1_in    = signed1_in & op1[W-1];
        neg2_in    = signed2_in & op2[W-1];
        // Two's-complement abs. The most negative value maps to itself. As an
        // unsigned magnitude that is still correct.
        mag1_in    = neg1_in ? (~op1 + 1'b1) : op1;
        mag2_in    = neg2_in ? (~op2 + 1'b1) : op2;
        div0_in    = func[2] && (op2 == '0);
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic ovf_in;
    logic mul_zero_in;
    logic early_in;

    always_comb begin
        ovf_in      = func[2] && !func[0] &&
                      (op1 == {1'b1, {(W-1){1'b0}}}) && (op2 == '1);
        mul_zero_in = !func[2] && ((op1 == '0) || (op2 == '0));
        early_in    = div0_in || ovf_in || mul_zero_in;
    end
`endif

    // -------------------------------------------------------------------------
    // One iteration of multiply or divide
    // -------------------------------------------------------------------------
    logic [W:0]   mul_sum;
    logic [W-1:0] mul_hi_d;
    logic [W-1:0] mul_lo_d;
    logic [W:0]   rem_shift;
    logic         rem_ge;
    logic [W-1:0] div_hi_d;
    logic [W-1:0] div_lo_d;
    logic [W-1:0] iter_hi_d;
    logic [W-1:0] iter_lo_d;

    always_comb begin
        // Shift-add: add the multiplicand when the multiplier LSB is set, then
        // shift the whole {carry, hi, lo} right by one.
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
        mul_hi_d = mul_sum[W:1];
        mul_lo_d = {mul_sum[0], lo_q[W-1:1]};

        // Restoring divide: bring in the next dividend bit and subtract when it
        // fits. The difference is below the divisor, so W bits hold it.
        rem_shift = {hi_q, lo_q[W-1]};
        rem_ge    = (rem_shift >= {1'b0, mcand_q});
        div_hi_d  = rem_ge ? (rem_shift[W-1:0] - mcand_q) : rem_shift[W-1:0];
        div_lo_d  = {lo_q[W-2:0], rem_ge};

        iter_hi_d = func_q[2] ? div_hi_d : mul_hi_d;
        iter_lo_d = func_q[2] ? div_lo_d : mul_lo_d;
    end

    // -------------------------------------------------------------------------
    // Sign correction and field select
    // -------------------------------------------------------------------------
    logic [2*W-1:0] prod;
    logic [2*W-1:0] prod_s;
    logic [W-1:0]   quot_s;
    logic [W-1:0]   rem_s;
    logic [W-1:0]   result_d;

    always_comb begin
        prod   = {hi_q, lo_q};
        prod_s = (sign1_q ^ sign2_q) ? (~prod + 1'b1) : prod;
        // For divide-by-zero the quotient is all ones whatever the signs.
        quot_s = div0_q ? '1 : ((sign1_q ^ sign2_q) ? (~lo_q + 1'b1) : lo_q);
        rem_s  = sign1_q ? (~hi_q + 1'b1) : hi_q;

        result_d = rem_s;
        case (func_q)
            F_MUL:                    result_d = prod_s[W-1:0];
            F_MULH, F_MULHSU, F_MULHU: result_d = prod_s[2*W-1:W];
            F_DIV, F_DIVU:            result_d = quot_s;
            default:                  result_d = rem_s;
        endcase
    end

    // -------------------------------------------------------------------------
    // Control FSM with registered handshake outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            func_q      <= '0;
            sign1_q     <= 1'b0;
            sign2_q     <= 1'b0;
            div0_q      <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            mcand_q     <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else if (flush) begin
            // Abort. The last result stays readable but is no longer valid.
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        func_q     <= func;
                        sign1_q    <= neg1_in;
                        sign2_q    <= neg2_in;
                        div0_q     <= div0_in;
                        hi_q       <= '0;
                        // Multiply: lo holds the multiplier and mcand holds op1.
                        // Divide: lo holds the dividend and mcand holds the divisor.
                        lo_q       <= func[2] ? mag1_in : mag2_in;
                        mcand_q    <= func[2] ? mag2_in : mag1_in;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= S_CALC;
`ifdef MULDIV_EARLY_OUT_EN
                        // Preload the registers with what CALC would have left.
                        // Overflow needs no preload: quotient magnitude is op1.
                        if (early_in) begin
                            state_q <= S_FIX;
                            if (div0_in) begin
                                hi_q <= mag1_in;
                            end
                            if (mul_zero_in) begin
                                lo_q <= '0;
                            end
                        end
`endif
                    end
                end
                S_CALC: begin
                    hi_q  <= iter_hi_d;
                    lo_q  <= iter_lo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LastCnt) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    result_q    <= result_d;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DONE;
                end
                S_DONE: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//
// Directed bench for muldiv_unit (DataWidth = 32). Each request's expected
// result comes from a plain-arithmetic model. The model value is queued at
// acceptance. One compare process checks result against the queue head on
// every cycle out_valid is high. The driver also checks each op against a
// hand-computed literal, the handshake latency, hold stability, flush and
// reset behaviour.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int W = 32;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int EarlyLat = 2;
`else
    localparam int EarlyLat = W + 2;
`endif
    localparam int FullLat = W + 2;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    func;
    logic [W-1:0]  op1;
    logic [W-1:0]  op2;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;

    int n_checks = 0;
    int n_errors = 0;
    logic [W-1:0] exp_q[$];

    muldiv_unit #(.DataWidth(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .func      (func),
        .op1       (op1),
        .op2       (op2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, req);
        end
    endtask

    // RV32M semantics from plain 64-bit arithmetic.
    function automatic logic [W-1:0] model(input logic [2:0] f, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        longint       sa;
        longint       sb;
        longint       ub;
        longint       p;
        logic [63:0]  up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'h0, b});
        up = {32'h0, a} * {32'h0, b};
        case (f)
            3'd0: return up[31:0];
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: return up[63:32];
            3'd4: begin
                if (b == 0) return '1;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: return (b == 0) ? '1 : (a / b);
            3'd6: begin
                if (b == 0) return a;
                p = sa % sb;
                return p[31:0];
            end
            default: return (b == 0) ? a : (a % b);
        endcase
    endfunction

    // Compare process: the held result must match the model on every valid cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid) begin
                if (exp_q.size() == 0) begin
                    check("stale_out_valid", {31'b0, out_valid}, 32'd0);
                end else begin
                    check("model_result", result, exp_q[0]);
                    check("in_ready_in_done", {31'b0, in_ready}, 32'd0);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // One complete transaction. Call at posedge+1 with the unit in IDLE.
    task automatic run_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] req, input int lat_req, input int hold,
                          input string name);
        int edges;
        bit seen;
        func     = f;
        op1      = a;
        op2      = b;
        in_valid = 1'b1;
        @(negedge clk);
        check({name, "_in_ready_idle"}, {31'b0, in_ready}, 32'd1);
        @(posedge clk);                       // accepting edge
        exp_q.push_back(model(f, a, b));
        #1;
        in_valid = 1'b0;
        func     = 3'($urandom);               // later input changes must be ignored
        op1      = $urandom;
        op2      = $urandom;
        edges    = 0;
        seen     = 1'b0;
        while (!seen && edges < 200) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
            end else begin
                if (in_ready !== 1'b0) check({name, "_in_ready_busy"}, {31'b0, in_ready}, 32'd0);
                @(posedge clk);
                edges++;
            end
        end
        if (!seen) begin
            check({name, "_timeout"}, 32'd0, 32'd1);
            @(posedge clk);
            #1;
            return;
        end
        // The first edge that sees out_valid high, counting from the accepting edge.
        check({name, "_latency"}, 32'(edges + 1), 32'(lat_req));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            check({name, "_hold_valid"}, {31'b0, out_valid}, 32'd1);
            check({name, "_hold_result"}, result, req);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);                       // handshake edge
        #1 out_ready = 1'b0;
        @(negedge clk);
        check({name, "_result"}, result, req);
        check({name, "_valid_drop"}, {31'b0, out_valid}, 32'd0);
        check({name, "_in_ready_back"}, {31'b0, in_ready}, 32'd1);
        $display("op %s func=%0d op1=0x%08h op2=0x%08h result=0x%08h latency=%0d",
                 name, f, a, b, result, edges + 1);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]   f;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        bit           early;
    } vec_t;

    vec_t vecs [0:18] = '{
        '{3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0},  // MUL 7*-3
        '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0},  // MULH
        '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0},  // MULHU
        '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0},  // MULHSU
        '{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0},  // DIV -7/2
        '{3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0},  // REM -7/2
        '{3'd5, 32'd100,      32'd7,        32'd14,       1'b0},  // DIVU
        '{3'd7, 32'd100,      32'd7,        32'd2,        1'b0},  // REMU
        '{3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1},  // DIV by 0
        '{3'd6, 32'd5,        32'd0,        32'd5,        1'b1},  // REM by 0
        '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1},  // DIV overflow
        '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1},  // REM overflow
        '{3'd4, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 1'b1},  // DIV -5/0
        '{3'd6, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1'b1},  // REM -5/0
        '{3'd0, 32'd0,        32'd12345,    32'd0,        1'b1},  // MUL zero operand
        '{3'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 1'b0},  // MULH -2*3
        '{3'd2, 32'd3,        32'hFFFFFFFF, 32'h00000002, 1'b0},  // MULHSU 3*(2^32-1)
        '{3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0},  // DIV 7/-2
        '{3'd6, 32'd7,        32'hFFFFFFFE, 32'h00000001, 1'b0}   // REM 7/-2
    };

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        func      = '0;
        op1       = '0;
        op2       = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_result", result, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].r,
                   vecs[i].early ? EarlyLat : FullLat, 0, $sformatf("v%0d", i));
        end

        // Held result: 10 cycles with out_ready low.
        run_op(3'd0, 32'd6, 32'd7, 32'd42, FullLat, 10, "hold");

        // Flush at CALC cycle 10, with a simultaneous request that must be ignored.
        func     = 3'd5;
        op1      = 32'd1000;
        op2      = 32'd3;
        in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(3'd5, 32'd1000, 32'd3));
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        flush    = 1'b1;
        in_valid = 1'b1;
        func     = 3'd4;
        op1      = 32'd77;
        op2      = 32'd7;
        exp_q.delete();
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_in_ready", {31'b0, in_ready}, 32'd1);
        check("flush_out_valid", {31'b0, out_valid}, 32'd0);
        check("flush_result_kept", result, 32'd42);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1)
                check("flush_quiet", {30'b0, out_valid, in_ready}, 32'd1);
        end
        n_checks++;   // the quiet window above counts as one comparison
        $display("op flush idle_after=1 result=0x%08h", result);
        @(posedge clk);
        #1;

        // Reset mid-CALC.
        func     = 3'd4;
        op1      = 32'd1000;
        op2      = 32'd9;
        in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(3'd4, 32'd1000, 32'd9));
        #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        exp_q.delete();
        #1;
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0)
                check("rst_quiet", {31'b0, out_valid}, 32'd0);
        end
        $display("op reset idle_after=1 result=0x%08h", result);
        @(posedge clk);
        #1;

        run_op(3'd5, 32'd9, 32'd3, 32'd3, FullLat, 0, "divu_after");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
